// File: rtl/mem_block_copier_pkg.sv
// mem_block_copier_pkg: FSM state encoding and word stride shared by the block copier
package mem_block_copier_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
  localparam int STRIDE = 4;
endpackage

// File: rtl/mem_block_copier.sv
// mem_block_copier: DMA word copier; in: clk reset start src_adr dst_adr count memdata; out: busy done memwrite adr writedata
module mem_block_copier
  import mem_block_copier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src_adr,
  input  logic [WIDTH-1:0] dst_adr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata
);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);
  state_t state;
  logic [WIDTH-1:0] src_ptr, dst_ptr, data_reg, src_al, dst_al;
  logic [CNT_W-1:0] remaining;
  logic last;
  assign src_al = src_adr & ~WIDTH'(3);
  assign dst_al = dst_adr & ~WIDTH'(3);
  assign last = remaining == CNT_W'(1);
  assign writedata = data_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      remaining <= '0;
      data_reg <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      memwrite <= 1'b0;
      adr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_ptr <= src_al;
          dst_ptr <= dst_al;
          remaining <= count;
          state <= |count ? READ : DONE;
          busy <= |count;
          done <= ~|count;
          adr <= |count ? src_al : '0;
        end
        READ: begin
          data_reg <= memdata;
          state <= WRITE;
          adr <= dst_ptr;
          memwrite <= 1'b1;
        end
        WRITE: begin
          src_ptr <= src_ptr + STEP;
          dst_ptr <= dst_ptr + STEP;
          remaining <= remaining - CNT_W'(1);
          memwrite <= 1'b0;
          state <= last ? DONE : READ;
          busy <= ~last;
          done <= last;
          adr <= last ? '0 : src_ptr + STEP;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier: randomized self-checking bench with a trace-level copy model
module tb_mem_block_copier;
  logic clk = 0, reset, start;
  logic [31:0] src_adr, dst_adr, adr, writedata, memdata;
  logic [15:0] count;
  logic busy, done, memwrite;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  typedef struct packed {logic busy, done, mw, ca; logic [31:0] adr, wd;} exp_t;
  exp_t q[$];
  logic [31:0] rd_log[$], wr_log[$];
  int n_chk = 0, n_fail = 0, wr_cnt = 0, done_cnt = 0;
  logic chk_en = 0;

  mem_block_copier #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
    .count(count), .busy(busy), .done(done), .memwrite(memwrite), .adr(adr),
    .writedata(writedata), .memdata(memdata)
  );

  always #5 clk = ~clk;
  assign memdata = mem[adr[11:2]];

  always @(posedge clk) begin
    if (memwrite === 1'b1) begin
      mem[adr[11:2]] <= writedata;
      wr_cnt++;
      wr_log.push_back(adr);
    end
    if (busy === 1'b1 && memwrite === 1'b0) rd_log.push_back(adr);
    if (done === 1'b1) done_cnt++;
  end

  always @(negedge clk) if (chk_en) begin
    exp_t e;
    e = q.size() > 0 ? q.pop_front() : exp_t'{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    n_chk++;
    if (busy !== e.busy || done !== e.done || memwrite !== e.mw ||
        (e.ca && adr !== e.adr) || (e.mw && writedata !== e.wd)) begin
      n_fail++;
      $display("FAIL cycle@%0t: got busy=%b done=%b mw=%b adr=%h wd=%h, expected busy=%b done=%b mw=%b adr=%h wd=%h",
               $time, busy, done, memwrite, adr, writedata, e.busy, e.done, e.mw, e.adr, e.wd);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem[a[11:2]] = v;
    ref_mem[a[11:2]] = v;
  endtask

  // Expected bus trace of one copy; only the first 'keep' words land in the reference memory.
  task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n, input int keep);
    logic [31:0] sa, da, v, ra, wa;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      ra = sa + 32'(4 * i);
      wa = da + 32'(4 * i);
      v = ref_mem[ra[11:2]];
      q.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b1, ra, 32'h0});
      q.push_back(exp_t'{1'b1, 1'b0, 1'b1, 1'b1, wa, v});
      if (i < keep) ref_mem[wa[11:2]] = v;
    end
    q.push_back(exp_t'{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
  endtask

  task automatic check_mem(input string name);
    int bad = -1;
    for (int i = 0; i < 1024; i++) if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: mem word %0d got %h expected %h", name, bad, mem[bad], ref_mem[bad]);
    end
  endtask

  task automatic do_job(input logic [31:0] s, input logic [31:0] d, input int n,
                        input int exp_lat, input bit poke_done, input bit noise, input int inj);
    int lat;
    rd_log.delete();
    wr_log.delete();
    @(negedge clk); #1;
    src_adr = s; dst_adr = d; count = 16'(n); start = 1;
    plan(s, d, n, n);
    chk("model_trace_len", 32'(q.size()), 32'(exp_lat));
    for (lat = 1; lat <= 200; lat++) begin
      @(negedge clk); #1;
      if (done === 1'b1) break;
      start = (lat == inj) || (noise && $urandom_range(0, 2) == 0);
      src_adr = lat == inj ? 32'h200 : $urandom;
      dst_adr = lat == inj ? 32'h280 : $urandom;
      count = 16'($urandom_range(1, 5));
    end
    chk("done_latency", 32'(lat), 32'(exp_lat));
    start = poke_done;
    src_adr = 32'h40; dst_adr = 32'h300; count = 16'd5;
    @(negedge clk); #1;
    start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wb, db;
    logic [31:0] s, d, v;
    reset = 1; start = 0; src_adr = 0; dst_adr = 0; count = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    poke(32'h40, 32'h1111_1111); poke(32'h44, 32'h2222_2222); poke(32'h48, 32'h3333_3333);
    poke(32'hFFFF_FFF8, 32'hAAAA_0001); poke(32'hFFFF_FFFC, 32'hAAAA_0002); poke(32'h0, 32'hAAAA_0003);
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) begin @(negedge clk); #1; end
    chk("reset_writedata", writedata, 32'h0);
    reset = 0;

    wb = wr_cnt; db = done_cnt;
    do_job(32'h40, 32'h80, 3, 7, 1, 0, 0);
    chk("t1_mem80", mem[32], 32'h1111_1111);
    chk("t1_mem84", mem[33], 32'h2222_2222);
    chk("t1_mem88", mem[34], 32'h3333_3333);
    chk("t1_writes", 32'(wr_cnt - wb), 32'd3);
    chk("t1_done_pulses", 32'(done_cnt - db), 32'd1);
    check_mem("t1_mem");

    wb = wr_cnt; db = done_cnt;
    do_job(32'h44, 32'h90, 0, 1, 0, 0, 0);
    chk("t2_writes", 32'(wr_cnt - wb), 32'd0);
    chk("t2_done_pulses", 32'(done_cnt - db), 32'd1);
    check_mem("t2_mem");

    wb = wr_cnt; db = done_cnt;
    do_job(32'h40, 32'h180, 4, 9, 0, 0, 3);
    chk("t3_writes", 32'(wr_cnt - wb), 32'd4);
    chk("t3_done_pulses", 32'(done_cnt - db), 32'd1);
    chk("t3_last_write_adr", wr_log[3], 32'h18C);
    check_mem("t3_mem");

    wb = wr_cnt; db = done_cnt;
    @(negedge clk); #1;
    src_adr = 32'h500; dst_adr = 32'h600; count = 16'd8; start = 1;
    plan(32'h500, 32'h600, 8, 2);
    @(negedge clk); #1;
    start = 0;
    repeat (4) begin @(negedge clk); #1; end
    reset = 1;
    q.delete();
    @(negedge clk); #1;
    reset = 0;
    chk("t4_memwrite_after_reset", 32'(memwrite), 32'd0);
    chk("t4_writes", 32'(wr_cnt - wb), 32'd2);
    chk("t4_done_pulses", 32'(done_cnt - db), 32'd0);
    chk("t4_writedata", writedata, 32'h0);
    check_mem("t4_mem");

    do_job(32'h43, 32'h86, 1, 3, 0, 0, 0);
    chk("t5_read_adr", rd_log[0], 32'h40);
    chk("t5_write_adr", wr_log[0], 32'h84);
    chk("t5_mem84", mem[33], 32'h1111_1111);

    do_job(32'hFFFF_FFF8, 32'h100, 3, 7, 0, 0, 0);
    chk("t6_read0", rd_log[0], 32'hFFFF_FFF8);
    chk("t6_read1", rd_log[1], 32'hFFFF_FFFC);
    chk("t6_read2", rd_log[2], 32'h0000_0000);
    chk("t6_mem100", mem[64], 32'hAAAA_0001);
    chk("t6_mem104", mem[65], 32'hAAAA_0002);
    chk("t6_mem108", mem[66], 32'hAAAA_0003);
    check_mem("t6_mem");

    v = mem[256];
    do_job(32'h400, 32'h404, 3, 7, 0, 0, 0);
    chk("t7_overlap0", mem[257], v);
    chk("t7_overlap2", mem[259], v);

    for (int k = 0; k < 12; k++) begin
      int n;
      n = $urandom_range(0, 6);
      s = $urandom;
      d = $urandom;
      do_job(s, d, n, n == 0 ? 1 : 2 * n + 1, 1'($urandom_range(0, 1)), 1, 0);
      check_mem("rand_mem");
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
